// File: rtl/instr_decode_stage.sv
// instr_decode_stage: decodes fetched instructions into a 2-entry skid buffer with run/halt tracking
module instr_decode_stage #(
  parameter int         PC_W    = 16,
  parameter logic [6:0] HALT_OP = 7'h7F
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            f_valid,
  input  logic [15:0]     f_instr,
  input  logic [PC_W-1:0] f_pc,
  output logic            f_ready,
  input  logic            flush,
  output logic            d_valid,
  input  logic            d_ready,
  output logic [6:0]      d_opcode,
  output logic [8:0]      d_imm,
  output logic [1:0]      d_imm_sel,
  output logic            d_reg_sel,
  output logic [PC_W-1:0] d_pc,
  output logic            halted
);
  localparam int EW = 19 + PC_W;
  typedef enum logic {RUN, HALTED} state_t;
  state_t          state_q, state_d;
  logic            ov_q, ov_d, sv_q, sv_d, f_ready_q, f_ready_d;
  logic [EW-1:0]   o_q, o_d, s_q, s_d, in_ent;
  logic            acc, out_free;
  // decode the incoming word (selector equals the class; register bit only for classes 01/10)
  always_comb begin
    acc      = f_valid && f_ready_q;
    out_free = !ov_q || d_ready;
    in_ent   = {f_instr[15:9], f_instr[8:0], f_instr[15:14],
                (f_instr[15] ^ f_instr[14]) & f_instr[8], f_pc};
  end
  // skid buffer load rules, halt tracking and registered upstream ready
  always_comb begin
    ov_d    = ov_q;
    sv_d    = sv_q;
    o_d     = o_q;
    s_d     = s_q;
    state_d = state_q;
    if (flush) begin
      ov_d    = 1'b0;
      sv_d    = 1'b0;
      state_d = RUN;
    end else begin
      if (out_free) begin
        if (sv_q) begin
          o_d  = s_q;
          ov_d = 1'b1;
          sv_d = acc;
          s_d  = acc ? in_ent : s_q;
        end else begin
          ov_d = acc;
          o_d  = acc ? in_ent : o_q;
        end
      end else if (acc) begin
        sv_d = 1'b1;
        s_d  = in_ent;
      end
      state_d = (acc && f_instr[15:9] == HALT_OP) ? HALTED : state_q;
    end
    f_ready_d = !sv_d && state_d == RUN;
  end
  // state registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q      <= 1'b0;
      sv_q      <= 1'b0;
      o_q       <= '0;
      s_q       <= '0;
      state_q   <= RUN;
      f_ready_q <= 1'b1;
    end else begin
      ov_q      <= ov_d;
      sv_q      <= sv_d;
      o_q       <= o_d;
      s_q       <= s_d;
      state_q   <= state_d;
      f_ready_q <= f_ready_d;
    end
  end
  assign d_valid = ov_q;
  assign {d_opcode, d_imm, d_imm_sel, d_reg_sel, d_pc} = o_q;
  assign halted  = state_q == HALTED;
  assign f_ready = f_ready_q;
endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage: scoreboard bench with directed scenarios and random traffic
module tb_instr_decode_stage;
  localparam int PC_W = 16;
  logic            clk = 0, rst_n = 0, f_valid = 0, flush = 0, d_ready = 0;
  logic [15:0]     f_instr = 0;
  logic [PC_W-1:0] f_pc = 0;
  logic            f_ready, d_valid, d_reg_sel, halted;
  logic [6:0]      d_opcode;
  logic [8:0]      d_imm;
  logic [1:0]      d_imm_sel;
  logic [PC_W-1:0] d_pc;
  instr_decode_stage #(.PC_W(PC_W), .HALT_OP(7'h7F)) dut (
    .clk(clk), .rst_n(rst_n), .f_valid(f_valid), .f_instr(f_instr), .f_pc(f_pc),
    .f_ready(f_ready), .flush(flush), .d_valid(d_valid), .d_ready(d_ready),
    .d_opcode(d_opcode), .d_imm(d_imm), .d_imm_sel(d_imm_sel), .d_reg_sel(d_reg_sel),
    .d_pc(d_pc), .halted(halted));
  always #5 clk = ~clk;
  typedef struct packed {
    logic [6:0] op; logic [8:0] imm; logic [1:0] sel; logic rs; logic [PC_W-1:0] pc;
  } ent_t;
  ent_t q[$];
  bit   m_halt = 0, last_acc = 0;
  int   total = 0, bad = 0;
  function automatic ent_t model(input logic [15:0] i, input logic [PC_W-1:0] p);
    ent_t e;
    int cls = int'(i[15:14]);
    e.op  = i[15:9];
    e.imm = i[8:0];
    e.sel = i[15:14];
    e.rs  = (cls == 1 || cls == 2) ? i[8] : 1'b0;
    e.pc  = p;
    return e;
  endfunction
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", n, a, e, $time);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  // reference model: what the edge about to come does to the queue of buffered entries
  always @(negedge clk) begin
    last_acc = 0;
    if (!rst_n || flush) begin
      q.delete();
      m_halt = 0;
    end else if (f_valid && f_ready) begin
      last_acc = 1;
      q.push_back(model(f_instr, f_pc));
      if (f_instr[15:9] == 7'h7F) m_halt = 1;
    end
  end
  // monitor: every output transfer must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n && !flush && d_valid && d_ready) begin
      if (q.size() == 0) chk("unexpected_out", 1, 0);
      else chk("entry", {d_opcode, d_imm, d_imm_sel, d_reg_sel, d_pc}, q.pop_front());
    end
  end
  // monitor: handshake and status signals follow the model occupancy
  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      chk("d_valid", d_valid, q.size() > 0);
      chk("f_ready", f_ready, !m_halt && q.size() < 2);
      chk("halted", halted, m_halt);
    end
  end
  task automatic send(input logic [15:0] ins, input int max, output bit ok);
    f_valid = 1;
    f_instr = ins;
    f_pc = 16'($urandom);
    ok = 0;
    for (int k = 0; k < max && !ok; k++) begin
      cyc();
      ok = last_acc;
    end
    f_valid = 0;
  endtask
  initial begin
    bit ok;
    logic [15:0] cls_list [3] = '{16'h4180, 16'h8113, 16'hC0AA};
    #12;
    chk("rst_out", {d_valid, f_ready, halted, d_opcode, d_imm, d_imm_sel, d_reg_sel, d_pc}, 64'h2 << 35);
    cyc();
    rst_n = 1;
    d_ready = 1;
    f_valid = 1; f_instr = 16'h01FF; f_pc = 16'h0010;
    cyc();
    f_valid = 0;
    chk("t1_out", {d_valid, d_opcode, d_imm, d_imm_sel, d_reg_sel, d_pc}, {1'b1, 7'h00, 9'h1FF, 2'b00, 1'b0, 16'h0010});
    cyc();
    for (int i = 0; i < 3; i++) begin
      f_valid = 1; f_instr = cls_list[i]; f_pc = 16'(i);
      cyc();
    end
    f_valid = 0;
    repeat (3) cyc();
    d_ready = 0;
    send(16'h0A01, 5, ok); chk("t3_a_acc", ok, 1);
    send(16'h4A02, 5, ok); chk("t3_b_acc", ok, 1);
    send(16'h8A03, 3, ok); chk("t3_c_blocked", ok, 0);
    chk("t3_hold", {d_valid, d_opcode, d_imm}, {1'b1, 7'h05, 9'h001});
    d_ready = 1;
    send(16'h8A03, 5, ok); chk("t3_c_acc", ok, 1);
    repeat (4) cyc();
    send(16'hFE00, 5, ok); chk("t4_halt_acc", ok, 1);
    chk("t4_halted", {halted, f_ready}, 2'b10);
    chk("t4_op", d_opcode, 7'h7F);
    send(16'h0001, 4, ok); chk("t4_blocked", ok, 0);
    flush = 1; cyc(); flush = 0;
    cyc();
    d_ready = 0;
    send(16'h2222, 5, ok);
    send(16'hFE00, 5, ok);
    chk("t5_full", {d_valid, halted, f_ready}, 3'b110);
    flush = 1; f_valid = 1; f_instr = 16'h1234;
    cyc();
    flush = 0; f_valid = 0;
    chk("t5_flushed", {d_valid, halted, f_ready}, 3'b001);
    d_ready = 1;
    repeat (3) cyc();
    d_ready = 0;
    send(16'h3333, 5, ok);
    send(16'h4444, 5, ok);
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    chk("t6_async", {d_valid, f_ready, halted}, 3'b010);
    cyc(); cyc();
    rst_n = 1;
    d_ready = 1;
    send(16'h5555, 5, ok); chk("t6_after", ok, 1);
    repeat (3) cyc();
    for (int n = 0; n < 400; n++) begin
      f_valid = 1'($urandom);
      f_instr = {($urandom_range(0, 19) == 0) ? 7'h7F : 7'($urandom), 9'($urandom)};
      f_pc = 16'($urandom);
      d_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 24) == 0;
      cyc();
    end
    f_valid = 0; flush = 0; d_ready = 1;
    for (int k = 0; k < 10 && q.size() > 0; k++) cyc();
    chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
